// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Purpose: single-outstanding instruction fetch unit. It requests a word at
//          pc, captures it in a register, then waits for the consumer to
//          advance or redirect the PC. A halt request parks the unit until
//          reset.
// Ports:
//   clk, resetn        rising-edge clock, async active-low reset
//   mem_req/mem_addr   fetch request and address (mem_addr == pc)
//   mem_ready/mem_rdata memory response (data valid when mem_ready=1)
//   pc_inc             advance to pc+4 (when holding an instruction)
//   jump/jump_target   redirect to word-aligned jump_target
//   halt               stop fetching until reset
//   instruction        registered fetched word
//   instr_valid        instruction holds a freshly fetched word
//   pc                 address of current / pending instruction
//   halted             unit is parked in HALTED
// ----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned   AW       = 32,
   parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [AW-1:0] NOP_WORD = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          resetn,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ready,
   input  logic [AW-1:0] mem_rdata,
   input  logic          pc_inc,
   input  logic          jump,
   input  logic [AW-1:0] jump_target,
   input  logic          halt,
   output logic [AW-1:0] instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          halted
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [AW-1:0]   instr_q, instr_d;
   logic            valid_q, valid_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic; priority halt > jump > pc_inc > mem_ready
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      unique case (state_q)
         FETCH: begin
            // jump / pc_inc are meaningless until the pending word arrives
            if (halt) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (mem_ready) begin
               state_d = HOLD;
               instr_d = mem_rdata;
               valid_d = 1'b1;
            end
         end
         HOLD: begin
            if (halt) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (jump) begin
               state_d = FETCH;
               pc_d    = jump_target & ~AW'(3);
               valid_d = 1'b0;
            end else if (pc_inc) begin
               state_d = FETCH;
               pc_d    = pc_q + AW'(4);
               valid_d = 1'b0;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = HALTED;
            valid_d = 1'b0;
         end
      endcase
   end

   // Request is gated by reset so the bus stays quiet while held in reset
   assign mem_req     = resetn && (state_q == FETCH);
   assign mem_addr    = pc_q;
   assign pc          = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign halted      = (state_q == HALTED);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-003 Parameter: NOP_WORD, default 32'h0000_0000, the instruction register value after reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: resetn  input  1  asynchronous active-low reset.
REQ-006 Port: mem_req  output  1  fetch request to instruction memory.
REQ-007 Port: mem_addr  output  32  fetch address; always equals pc.
REQ-008 Port: mem_ready  input  1  memory has returned valid data on mem_rdata this cycle.
REQ-009 Port: mem_rdata  input  32  fetched instruction word.
REQ-010 Port: pc_inc  input  1  consumer request to advance to the next sequential instruction.
REQ-011 Port: jump  input  1  consumer request to redirect the PC.
REQ-012 Port: jump_target  input  32  redirect address.
REQ-013 Port: halt  input  1  stop fetching, for example on an invalid instruction.
REQ-014 Port: instruction  output  32  registered instruction presented downstream.
REQ-015 Port: instr_valid  output  1  instruction holds a freshly fetched word.
REQ-016 Port: pc  output  32  address of the current or pending instruction.
REQ-017 Port: halted  output  1  block is in the HALTED state.

Function
REQ-018 The block SHALL implement three states: FETCH, HOLD and HALTED, all registered.
REQ-019 In FETCH, mem_req SHALL be 1.
REQ-020 On an edge in FETCH where mem_ready=1, the block SHALL set instruction<=mem_rdata and instr_valid<=1, and move to HOLD.
REQ-021 In FETCH with mem_ready=0, the block SHALL hold state; pc_inc and jump SHALL be ignored.
REQ-022 In HOLD, mem_req SHALL be 0 and instruction SHALL remain stable.
REQ-023 On an edge in HOLD with jump=1, the block SHALL set pc<={jump_target[31:2],2'b00} and instr_valid<=0, and move to FETCH.
REQ-024 On an edge in HOLD with jump=0 and pc_inc=1, the block SHALL set pc<=pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0) and instr_valid<=0, and move to FETCH.
REQ-025 In HOLD with neither jump nor pc_inc asserted, the block SHALL hold indefinitely.
REQ-026 Priority at any edge SHALL be: halt > jump > pc_inc > mem_ready.
REQ-027 On an edge with halt=1 in any state, the block SHALL enter HALTED; instr_valid<=0; pc and instruction are held.
REQ-028 In HALTED, mem_req=0 and halted=1; all inputs are ignored; only reset exits HALTED.
REQ-029 Minimum fetch latency: mem_ready=1 in the first FETCH cycle gives instr_valid=1 one edge later; each instruction costs at least two cycles.
REQ-030 mem_addr SHALL be combinationally equal to pc; pc SHALL change only at the edges defined in REQ-023, REQ-024 and reset.

Reset
REQ-031 On resetn=0, the block SHALL immediately and asynchronously set: state=FETCH, pc=RESET_PC, instruction=NOP_WORD, instr_valid=0, halted=0.
REQ-032 During reset, mem_req SHALL be 0; it goes to 1 combinationally once resetn=1 (state FETCH).
REQ-033 Reset asserted mid-fetch or while HALTED SHALL discard any pending mem_ready or pc_inc; the first post-reset fetch address is RESET_PC.

Verification
REQ-034 Basic fetch: reset, release; mem_ready=1 with mem_rdata=32'h1234_5678 -> next edge instruction=32'h1234_5678, instr_valid=1, pc=0, mem_req=0.
REQ-035 Sequential advance: in HOLD pulse pc_inc -> pc=4, instr_valid=0, mem_req=1, mem_addr=4; a 3-cycle mem_ready delay keeps state FETCH with pc unchanged.
REQ-036 Jump priority: in HOLD, jump=1 with jump_target=32'h0000_1003 and pc_inc=1 together -> pc=32'h0000_1000 (not pc+4).
REQ-037 Wrap: RESET_PC=32'hFFFF_FFFC, fetch, then pc_inc -> pc=0.
REQ-038 Halt: in FETCH, assert halt and mem_ready together -> HALTED, halted=1, instr_valid=0, instruction unchanged; later pc_inc/jump have no effect.
REQ-039 Async reset: assert resetn=0 between clock edges while HALTED -> outputs take reset values before the next edge; after release, fetch restarts at RESET_PC.
